irrigation_sequencer: RTL and testbench



---
 rtl/irrigation_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_irrigation_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_sequencer.sv
// Irrigation timer sequencer: conditions the sensor/switch inputs, selects a BCD minute preset and drives the timer and valve.
// Optional IRRIGATION_PAUSE_EN: an empty tank during RUN parks in PAUSE instead of abandoning the cycle.
module irrigation_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int COOL_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       h,
    input  logic       m,
    input  logic       l,
    input  logic       As,
    input  logic       Gt,
    input  logic       dry,
    input  logic       zero,
    output logic       load,
    output logic [1:0] min_tens,
    output logic [3:0] min_units,
    output logic       run,
    output logic       valve_open,
    output logic       done,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int NUM_IN = 6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
`ifdef IRRIGATION_PAUSE_EN
        S_PAUSE    = 3'd3,
`endif
        S_COOLDOWN = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] sync1_reg;
    logic [NUM_IN-1:0] sync2_reg;
    logic [NUM_IN-1:0] deb;

    assign raw_in = {dry, Gt, As, l, m, h};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Each debouncer accepts a new value after DEB_CYCLES consecutive differing samples.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_deb
            logic [3:0] cnt_reg;
            logic       val_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                    val_reg <= 1'b0;
                end else if (sync2_reg[gi] == val_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == 4'(DEB_CYCLES - 1)) begin
                    cnt_reg <= '0;
                    val_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end
            assign deb[gi] = val_reg;
        end
    endgenerate

    logic d_h, d_m, d_l, d_as, d_gt, d_dry;
    logic fault_cond, empty;

    assign {d_dry, d_gt, d_as, d_l, d_m, d_h} = deb;
    assign fault_cond = (d_h & ~d_m) | (d_m & ~d_l) | (d_as & d_gt);
    assign empty      = ~d_l;

    logic [1:0] preset_tens;
    logic [3:0] preset_units;

    always_comb begin
        preset_tens  = 2'd0;
        preset_units = 4'd0;
        if (d_gt) begin
            preset_tens = d_h ? 2'd3 : (d_m ? 2'd2 : 2'd1);
        end else begin
            preset_tens  = (d_h | d_m) ? 2'd1 : 2'd0;
            preset_units = d_m & ~d_h ? 4'd0 : 4'd5;
        end
    end

    state_t     state_reg, state_next;
    logic [7:0] cool_cnt_reg, cool_cnt_next;
    logic       run_first_reg;
    logic       done_next;

    always_comb begin
        state_next    = state_reg;
        cool_cnt_next = cool_cnt_reg;
        done_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (fault_cond)
                    state_next = S_FAULT;
                else if (d_dry & (d_as ^ d_gt) & ~empty)
                    state_next = S_LOAD;
            end
            S_LOAD: state_next = S_RUN;
            S_RUN: begin
                if (fault_cond) begin
                    state_next = S_FAULT;
                end else if (empty) begin
`ifdef IRRIGATION_PAUSE_EN
                    state_next = S_PAUSE;
`else
                    state_next = S_IDLE;
`endif
                end else if (zero & ~run_first_reg) begin
                    state_next = S_COOLDOWN;
                    done_next  = 1'b1;
                end
            end
`ifdef IRRIGATION_PAUSE_EN
            S_PAUSE: begin
                if (fault_cond)
                    state_next = S_FAULT;
                else if (~empty)
                    state_next = S_RUN;
            end
`endif
            S_COOLDOWN: begin
                // The entry cycle (done high) never counts a tick.
                if (fault_cond) begin
                    state_next = S_FAULT;
                end else if (tick & ~done) begin
                    if (cool_cnt_reg == 8'(COOL_TICKS - 1))
                        state_next = S_IDLE;
                    else
                        cool_cnt_next = cool_cnt_reg + 8'd1;
                end
            end
            S_FAULT: begin
                if (~fault_cond & ~d_dry)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (state_next != S_COOLDOWN)
            cool_cnt_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cool_cnt_reg  <= '0;
            run_first_reg <= 1'b0;
            load          <= 1'b0;
            min_tens      <= '0;
            min_units     <= '0;
            run           <= 1'b0;
            valve_open    <= 1'b0;
            done          <= 1'b0;
            alarm         <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cool_cnt_reg  <= cool_cnt_next;
            run_first_reg <= (state_next == S_RUN) && (state_reg != S_RUN);
            load          <= (state_next == S_LOAD);
            run           <= (state_next == S_RUN);
            valve_open    <= (state_next == S_RUN);
            done          <= done_next;
            alarm         <= (state_next == S_FAULT);
            if (state_reg == S_IDLE && state_next == S_LOAD) begin
                min_tens  <= preset_tens;
                min_units <= preset_units;
            end
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scoreboarded bench for irrigation_sequencer: stimulus queues expected state transitions, a negedge monitor checks them.
module tb_irrigation_sequencer;
    localparam int DEB  = 4;
    localparam int COOL = 10;
    localparam int LAT  = DEB + 3;   // pin change driven at negedge n shows as a new state at cycle n+LAT

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_COOL  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, zero = 1'b0;
    logic h = 1'b0, m = 1'b0, l = 1'b0, As = 1'b0, Gt = 1'b0, dry = 1'b0;
    logic       load, run, valve_open, done, alarm;
    logic [1:0] min_tens;
    logic [3:0] min_units;
    logic [2:0] state;

    irrigation_sequencer #(.DEB_CYCLES(DEB), .COOL_TICKS(COOL)) dut (
        .clk(clk), .rst(rst), .tick(tick), .h(h), .m(m), .l(l), .As(As), .Gt(Gt),
        .dry(dry), .zero(zero), .load(load), .min_tens(min_tens), .min_units(min_units),
        .run(run), .valve_open(valve_open), .done(done), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       ld, rn, vo, dn, al;
        logic [1:0] tens;
        logic [3:0] units;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cur;
    ev_t        mon_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_st = ST_IDLE;
    logic [1:0] mdl_tens = 2'd0;
    logic [3:0] mdl_units = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int preset_minutes(input int mode, input int lvl);
        // mode 0 = sprinkler, 1 = drip; lvl 0 = HIGH, 1 = MID, 2 = LOW
        return (mode == 0) ? 15 - 5 * lvl : 30 - 10 * lvl;
    endfunction

    task automatic expect_state(input int c, input logic [2:0] s, input logic dn);
        ev_t e;
        e.cyc   = c;
        e.st    = s;
        e.ld    = (s == ST_LOAD);
        e.rn    = (s == ST_RUN);
        e.vo    = (s == ST_RUN);
        e.dn    = dn;
        e.al    = (s == ST_FAULT);
        e.tens  = mdl_tens;
        e.units = mdl_units;
        exp_q.push_back(e);
    endtask

    task automatic set_inputs(input int mode, input int lvl);
        As = (mode == 0);
        Gt = (mode == 1);
        h  = (lvl == 0);
        m  = (lvl <= 1);
        l  = (lvl <= 2);
    endtask

    // Monitor: every state change must match the next queued transition; in between, outputs hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (state != prev_st) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_transition cyc=%0d state %0d->%0d", cyc, prev_st, state);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (cyc != mon_e.cyc || state !== mon_e.st || load !== mon_e.ld || run !== mon_e.rn ||
                        valve_open !== mon_e.vo || done !== mon_e.dn || alarm !== mon_e.al ||
                        min_tens !== mon_e.tens || min_units !== mon_e.units) begin
                        n_fail++;
                        $display("FAIL transition: got cyc=%0d st=%0d ld=%b run=%b vo=%b dn=%b al=%b preset=%0d%0d, expected cyc=%0d st=%0d ld=%b run=%b vo=%b dn=%b al=%b preset=%0d%0d",
                                 cyc, state, load, run, valve_open, done, alarm, min_tens, min_units,
                                 mon_e.cyc, mon_e.st, mon_e.ld, mon_e.rn, mon_e.vo, mon_e.dn, mon_e.al,
                                 mon_e.tens, mon_e.units);
                    end else begin
                        $display("cyc=%0d state %0d->%0d ld=%b run=%b dn=%b al=%b preset=%0d%0d",
                                 cyc, prev_st, state, load, run, done, alarm, min_tens, min_units);
                    end
                    cur = mon_e;
                end
            end else begin
                n_checks++;
                if ({load, run, valve_open, done, alarm, min_tens, min_units} !==
                    {1'b0, cur.rn, cur.vo, 1'b0, cur.al, cur.tens, cur.units}) begin
                    n_fail++;
                    $display("FAIL steady_outputs cyc=%0d st=%0d: got ld=%b run=%b vo=%b dn=%b al=%b preset=%0d%0d, expected ld=0 run=%b vo=%b dn=0 al=%b preset=%0d%0d",
                             cyc, state, load, run, valve_open, done, alarm, min_tens, min_units,
                             cur.rn, cur.vo, cur.al, cur.tens, cur.units);
                end
            end
            prev_st = state;
        end
    end

    // Returns at the negedge inside the first RUN cycle.
    task automatic start_run(input int mode, input int lvl);
        int n;
        int mins;
        @(negedge clk);
        set_inputs(mode, lvl);
        repeat (LAT + 3) @(negedge clk);
        dry  = 1'b1;
        n    = cyc;
        mins = preset_minutes(mode, lvl);
        mdl_tens  = 2'(mins / 10);
        mdl_units = 4'(mins % 10);
        expect_state(n + LAT, ST_LOAD, 1'b0);
        expect_state(n + LAT + 1, ST_RUN, 1'b0);
        repeat (LAT + 1) @(negedge clk);
        dry = 1'b0;
    endtask

    // Called in the first RUN cycle; a zero there must be ignored.
    task automatic finish_run(input int k, input bit zero_glitch);
        int t;
        zero = zero_glitch;
        @(negedge clk);
        zero = 1'b0;
        repeat (k) @(negedge clk);
        zero = 1'b1;
        expect_state(cyc + 1, ST_COOL, 1'b1);
        @(negedge clk);
        zero = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int i = 0; i < COOL; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tick = 1'b1;
            t = cyc;
            if (i == COOL - 1)
                expect_state(t + 1, ST_IDLE, 1'b0);
            @(negedge clk);
            tick = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({state, load, run, valve_open, done, alarm, min_tens, min_units} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got st=%0d ld=%b run=%b vo=%b dn=%b al=%b preset=%0d%0d, expected all 0",
                     state, load, run, valve_open, done, alarm, min_tens, min_units);
        end
        rst = 1'b0;
        cur = '{cyc: 0, st: ST_IDLE, ld: 1'b0, rn: 1'b0, vo: 1'b0, dn: 1'b0, al: 1'b0, tens: 2'd0, units: 4'd0};
        mon_en = 1'b1;

        start_run(1, 0); finish_run(2, 1'b1);      // drip, HIGH -> 30 min
        start_run(0, 1); finish_run(0, 1'b0);      // sprinkler, MID -> 10 min

        // Non-monotonic levels: h without m.
        @(negedge clk);
        set_inputs(0, 0);
        repeat (LAT + 3) @(negedge clk);
        m = 1'b0; n = cyc;
        expect_state(n + LAT, ST_FAULT, 1'b0);
        repeat (LAT + 3) @(negedge clk);
        m = 1'b1; n = cyc;
        expect_state(n + LAT, ST_IDLE, 1'b0);
        repeat (LAT + 3) @(negedge clk);

        // Both modes with a dry request: fault, never a load.
        Gt = 1'b1; dry = 1'b1; n = cyc;
        expect_state(n + LAT, ST_FAULT, 1'b0);
        repeat (LAT + 3) @(negedge clk);
        Gt = 1'b0; dry = 1'b0; n = cyc;
        expect_state(n + LAT, ST_IDLE, 1'b0);
        repeat (LAT + 3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start_run(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            finish_run(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        // Short low-sensor glitch is filtered; a held one empties the tank.
        start_run(int'($urandom_range(0, 1)), 2);
        @(negedge clk);
        l = 1'b0;
        repeat (DEB - 1) @(negedge clk);
        l = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        l = 1'b0; n = cyc;
`ifdef IRRIGATION_PAUSE_EN
        expect_state(n + LAT, ST_PAUSE, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        l = 1'b1; n = cyc;
        expect_state(n + LAT, ST_RUN, 1'b0);
        repeat (LAT) @(negedge clk);
        finish_run(1, 1'b1);
`else
        expect_state(n + LAT, ST_IDLE, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        l = 1'b1;
        repeat (LAT + 3) @(negedge clk);
`endif

        // Asynchronous reset in the middle of RUN.
        start_run(1, 1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        {h, m, l, As, Gt, dry} = 6'b0;
        mdl_tens  = 2'd0;
        mdl_units = 4'd0;
        expect_state(cyc + 1, ST_IDLE, 1'b0);
        #1;
        n_checks++;
        if ({state, load, run, valve_open, done, alarm, min_tens, min_units} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d ld=%b run=%b vo=%b dn=%b al=%b preset=%0d%0d, expected all 0",
                     state, load, run, valve_open, done, alarm, min_tens, min_units);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_transitions: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
